// File: rtl/wash_pkg.sv
// ---------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the wash cycle scheduler slice.
//   - bcd8_t          : two-digit packed BCD value (tens in [7:4], units in [3:0])
//   - PH_* constants  : phase / FSM state encodings, also driven on the phase port
//   - T_*_DEFAULT     : default run and stop durations in BCD seconds
// ---------------------------------------------------------------------------
package wash_pkg;

   typedef logic [7:0] bcd8_t;

   localparam logic [2:0] PH_IDLE   = 3'd0;
   localparam logic [2:0] PH_FWD    = 3'd1;
   localparam logic [2:0] PH_STOP1  = 3'd2;
   localparam logic [2:0] PH_REV    = 3'd3;
   localparam logic [2:0] PH_STOP2  = 3'd4;
   localparam logic [2:0] PH_DONE   = 3'd5;
   localparam logic [2:0] PH_PAUSED = 3'd6;

   localparam bcd8_t T_RUN_DEFAULT  = 8'h60;
   localparam bcd8_t T_STOP_DEFAULT = 8'h05;

endpackage

// File: rtl/bcd_down_counter8.sv
// ---------------------------------------------------------------------------
// bcd_down_counter8
// Two-digit BCD down counter used as the phase countdown.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset, clears value to 00
//   load     : load load_val this clk (wins over en)
//   load_val : BCD value to load
//   en       : decrement by one BCD step this clk; value sticks at 00
//   value    : current BCD value
//   is_one   : value == 8'h01 (last second of the phase)
// ---------------------------------------------------------------------------
module bcd_down_counter8
   import wash_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  bcd8_t load_val,
   input  logic  en,
   output bcd8_t value,
   output logic  is_one
);

   bcd8_t value_reg;
   bcd8_t value_next;

   // Units borrow from tens; at 00 neither branch fires so the value holds.
   always_comb begin
      value_next = value_reg;
      if (value_reg[3:0] != 4'd0) begin
         value_next[3:0] = value_reg[3:0] - 4'd1;
      end else if (value_reg[7:4] != 4'd0) begin
         value_next[7:4] = value_reg[7:4] - 4'd1;
         value_next[3:0] = 4'd9;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_reg <= 8'h00;
      end else if (load) begin
         value_reg <= load_val;
      end else if (en) begin
         value_reg <= value_next;
      end
   end

   assign value  = value_reg;
   assign is_one = (value_reg == 8'h01);

endmodule

// File: rtl/wash_cycle_scheduler.sv
// ---------------------------------------------------------------------------
// wash_cycle_scheduler
// Sequences a wash program: FWD run, STOP1, REV run, STOP2, repeated for the
// selected number of cycles, with a pause/door interlock and blinking alarm.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   tick        : one-clk 1 Hz enable
//   start       : level, rising edge requests a program start
//   pause       : level, high holds the program
//   door_open   : level, high = door open (holds program and raises error)
//   cycles      : cycle count, sampled only on an accepted start
//   motor_fwd   : forward drive
//   motor_rev   : reverse drive
//   phase       : current phase (PH_* encoding)
//   remaining   : BCD seconds left in the current phase
//   cycles_left : cycles not yet completed, including the current one
//   done        : high in DONE
//   alarm       : blinking error indication
// Parameters:
//   T_RUN  : run phase duration, BCD seconds 01..99
//   T_STOP : stop phase duration, BCD seconds 01..99
// ---------------------------------------------------------------------------
module wash_cycle_scheduler
   import wash_pkg::*;
#(
   parameter bcd8_t T_RUN  = T_RUN_DEFAULT,
   parameter bcd8_t T_STOP = T_STOP_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   input  logic       door_open,
   input  logic [3:0] cycles,
   output logic       motor_fwd,
   output logic       motor_rev,
   output logic [2:0] phase,
   output logic [7:0] remaining,
   output logic [3:0] cycles_left,
   output logic       done,
   output logic       alarm
);

   logic [2:0] state_reg,       state_next;
   logic [2:0] resume_reg,      resume_next;
   logic [3:0] cycles_left_reg, cycles_left_next;
   logic       err_reg,         err_next;
   logic       blink_reg;
   logic       start_q_reg;
   logic       armed_reg;
   logic       motor_fwd_reg;
   logic       motor_rev_reg;

   logic       start_edge;
   logic       cnt_load;
   bcd8_t      cnt_load_val;
   logic       cnt_en;
   bcd8_t      cnt_value;
   logic       cnt_is_one;

   // start_q clears on reset, so a start held high through reset would look
   // like a fresh edge on the first clk afterwards. armed_reg masks that first
   // clk; by the second clk start_q holds the real level of start.
   assign start_edge = start & ~start_q_reg & armed_reg;

   bcd_down_counter8 u_countdown (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .value    (cnt_value),
      .is_one   (cnt_is_one)
   );

   always_comb begin
      state_next       = state_reg;
      resume_next      = resume_reg;
      cycles_left_next = cycles_left_reg;
      err_next         = err_reg;
      cnt_load         = 1'b0;
      cnt_load_val     = T_RUN;
      cnt_en           = 1'b0;

      case (state_reg)
         PH_IDLE, PH_DONE: begin
            if (start_edge) begin
               if ((cycles != 4'd0) && !door_open) begin
                  state_next       = PH_FWD;
                  cnt_load         = 1'b1;
                  cnt_load_val     = T_RUN;
                  cycles_left_next = cycles;
                  err_next         = 1'b0;
               end else begin
                  err_next = 1'b1;
               end
            end
         end

         PH_FWD, PH_STOP1, PH_REV, PH_STOP2: begin
            // Hold requests take priority; a coincident tick is dropped.
            if (pause || door_open) begin
               state_next  = PH_PAUSED;
               resume_next = state_reg;
               if (door_open) begin
                  err_next = 1'b1;
               end
            end else if (tick) begin
               if (cnt_is_one) begin
                  // Phase ends on its last second: load the next duration now
                  // so every phase spans exactly its parameter in ticks.
                  cnt_load = 1'b1;
                  case (state_reg)
                     PH_FWD: begin
                        state_next   = PH_STOP1;
                        cnt_load_val = T_STOP;
                     end
                     PH_STOP1: begin
                        state_next   = PH_REV;
                        cnt_load_val = T_RUN;
                     end
                     PH_REV: begin
                        state_next   = PH_STOP2;
                        cnt_load_val = T_STOP;
                     end
                     default: begin
                        if (cycles_left_reg == 4'd1) begin
                           state_next       = PH_DONE;
                           cnt_load_val     = 8'h00;
                           cycles_left_next = 4'd0;
                        end else begin
                           state_next       = PH_FWD;
                           cnt_load_val     = T_RUN;
                           cycles_left_next = cycles_left_reg - 4'd1;
                        end
                     end
                  endcase
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end

         PH_PAUSED: begin
            if (!pause && !door_open) begin
               state_next = resume_reg;
            end
         end

         default: begin
            state_next = PH_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= PH_IDLE;
         resume_reg      <= PH_IDLE;
         cycles_left_reg <= 4'd0;
         err_reg         <= 1'b0;
         blink_reg       <= 1'b0;
         start_q_reg     <= 1'b0;
         armed_reg       <= 1'b0;
         motor_fwd_reg   <= 1'b0;
         motor_rev_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         resume_reg      <= resume_next;
         cycles_left_reg <= cycles_left_next;
         err_reg         <= err_next;
         start_q_reg     <= start;
         armed_reg       <= 1'b1;
         // Motor flops follow state_next so they line up with state_reg.
         motor_fwd_reg   <= (state_next == PH_FWD);
         motor_rev_reg   <= (state_next == PH_REV);
         if (!err_reg) begin
            blink_reg <= 1'b0;
         end else if (tick) begin
            blink_reg <= ~blink_reg;
         end
      end
   end

   assign motor_fwd   = motor_fwd_reg;
   assign motor_rev   = motor_rev_reg;
   assign phase       = state_reg;
   assign remaining   = cnt_value;
   assign cycles_left = cycles_left_reg;
   assign done        = (state_reg == PH_DONE);
   assign alarm       = err_reg & blink_reg;

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wash_cycle_scheduler
// Two scheduler instances: u_a (T_RUN=03, T_STOP=01) and u_b (T_RUN=12,
// T_STOP=05) share all inputs. Each stimulus step pushes the expected state
// after the next clock edge; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_wash_cycle_scheduler;
   import wash_pkg::*;

   localparam bit SEL_A = 1'b0;
   localparam bit SEL_B = 1'b1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       door_open = 1'b0;
   logic [3:0] cycles = 4'd0;

   logic       a_fwd, a_rev, a_done, a_alarm;
   logic [2:0] a_phase;
   logic [7:0] a_rem;
   logic [3:0] a_cl;
   logic       b_fwd, b_rev, b_done, b_alarm;
   logic [2:0] b_phase;
   logic [7:0] b_rem;
   logic [3:0] b_cl;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      string      tag;
      int         due;
      bit         sel;
      logic [2:0] ph;
      logic [7:0] rem;
      logic [3:0] cl;
      logic       al;
   } exp_t;

   exp_t sb[$];

   // Test 1 expectations after each tick (T_RUN=03, T_STOP=01, 2 cycles).
   logic [2:0] t1_ph [16] = '{PH_FWD, PH_FWD, PH_STOP1, PH_REV, PH_REV, PH_REV, PH_STOP2,
                              PH_FWD, PH_FWD, PH_FWD, PH_STOP1, PH_REV, PH_REV, PH_REV,
                              PH_STOP2, PH_DONE};
   logic [7:0] t1_rem [16] = '{8'h02, 8'h01, 8'h01, 8'h03, 8'h02, 8'h01, 8'h01,
                               8'h03, 8'h02, 8'h01, 8'h01, 8'h03, 8'h02, 8'h01,
                               8'h01, 8'h00};

   wash_cycle_scheduler #(.T_RUN(8'h03), .T_STOP(8'h01)) u_a (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
      .door_open(door_open), .cycles(cycles),
      .motor_fwd(a_fwd), .motor_rev(a_rev), .phase(a_phase), .remaining(a_rem),
      .cycles_left(a_cl), .done(a_done), .alarm(a_alarm)
   );

   wash_cycle_scheduler #(.T_RUN(8'h12), .T_STOP(8'h05)) u_b (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
      .door_open(door_open), .cycles(cycles),
      .motor_fwd(b_fwd), .motor_rev(b_rev), .phase(b_phase), .remaining(b_rem),
      .cycles_left(b_cl), .done(b_done), .alarm(b_alarm)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic expect_next(input bit sel, input string tag, input logic [2:0] ph,
                              input logic [7:0] rem, input logic [3:0] cl, input logic al);
      exp_t e;
      e.tag = tag;
      e.due = cyc + 1;
      e.sel = sel;
      e.ph  = ph;
      e.rem = rem;
      e.cl  = cl;
      e.al  = al;
      sb.push_back(e);
   endtask

   task automatic step(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic go(input bit sel, input string tag, input logic t, input logic [2:0] ph,
                     input logic [7:0] rem, input logic [3:0] cl, input logic al);
      expect_next(sel, tag, ph, rem, cl, al);
      step(t);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      door_open = 1'b0;
      tick = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) begin
         expect_next(SEL_B, "rst_idle_b", PH_IDLE, 8'h00, 4'd0, 1'b0);
         go(SEL_A, "rst_idle_a", 1'b0, PH_IDLE, 8'h00, 4'd0, 1'b0);
      end
   endtask

   // Monitor: motor exclusivity every cycle, plus scoreboard entries now due.
   logic [2:0] o_ph;
   logic [7:0] o_rem;
   logic [3:0] o_cl;
   logic       o_fwd, o_rev, o_done, o_al;
   exp_t       mon_e;

   always @(negedge clk) begin
      chk_eq("overlap_a", int'(a_fwd & a_rev), 0);
      chk_eq("overlap_b", int'(b_fwd & b_rev), 0);
      while ((sb.size() != 0) && (sb[0].due <= cyc)) begin
         mon_e  = sb.pop_front();
         o_ph   = mon_e.sel ? b_phase : a_phase;
         o_rem  = mon_e.sel ? b_rem   : a_rem;
         o_cl   = mon_e.sel ? b_cl    : a_cl;
         o_fwd  = mon_e.sel ? b_fwd   : a_fwd;
         o_rev  = mon_e.sel ? b_rev   : a_rev;
         o_done = mon_e.sel ? b_done  : a_done;
         o_al   = mon_e.sel ? b_alarm : a_alarm;
         chk_eq({mon_e.tag, ".phase"}, int'(o_ph), int'(mon_e.ph));
         chk_eq({mon_e.tag, ".remaining"}, int'(o_rem), int'(mon_e.rem));
         chk_eq({mon_e.tag, ".cycles_left"}, int'(o_cl), int'(mon_e.cl));
         chk_eq({mon_e.tag, ".motor_fwd"}, int'(o_fwd), int'(mon_e.ph == PH_FWD));
         chk_eq({mon_e.tag, ".motor_rev"}, int'(o_rev), int'(mon_e.ph == PH_REV));
         chk_eq({mon_e.tag, ".done"}, int'(o_done), int'(mon_e.ph == PH_DONE));
         chk_eq({mon_e.tag, ".alarm"}, int'(o_al), int'(mon_e.al));
         $display("txn %-18s dut=%s phase=%0d rem=%02h cl=%0d fwd=%0b rev=%0b done=%0b alarm=%0b",
                  mon_e.tag, mon_e.sel ? "b" : "a", o_ph, o_rem, o_cl, o_fwd, o_rev, o_done, o_al);
      end
   end

   initial begin
      // Reset held for a few clocks: everything idle and zero.
      repeat (3) begin
         expect_next(SEL_B, "in_reset_b", PH_IDLE, 8'h00, 4'd0, 1'b0);
         go(SEL_A, "in_reset_a", 1'b0, PH_IDLE, 8'h00, 4'd0, 1'b0);
      end
      do_reset();

      // Normal run on u_a: 2 cycles, DONE after 16 ticks; cycles changes mid-run are ignored.
      cycles = 4'd2;
      start = 1'b1;
      go(SEL_A, "start", 1'b0, PH_FWD, 8'h03, 4'd2, 1'b0);
      start = 1'b0;
      cycles = 4'd9;
      for (int i = 0; i < 16; i++) begin
         go(SEL_A, "run_tick", 1'b1, t1_ph[i], t1_rem[i],
            (i < 7) ? 4'd2 : ((i < 15) ? 4'd1 : 4'd0), 1'b0);
         go(SEL_A, "run_hold", 1'b0, t1_ph[i], t1_rem[i],
            (i < 7) ? 4'd2 : ((i < 15) ? 4'd1 : 4'd0), 1'b0);
      end
      go(SEL_A, "done_hold", 1'b1, PH_DONE, 8'h00, 4'd0, 1'b0);

      // BCD borrow on u_b (T_RUN=12): 12 down to 01, then STOP1 loads 05.
      do_reset();
      cycles = 4'd1;
      start = 1'b1;
      go(SEL_B, "start_b", 1'b0, PH_FWD, 8'h12, 4'd1, 1'b0);
      start = 1'b0;
      for (int i = 11; i >= 1; i--) go(SEL_B, "borrow", 1'b1, PH_FWD, to_bcd(i), 4'd1, 1'b0);
      go(SEL_B, "stop1_load", 1'b1, PH_STOP1, 8'h05, 4'd1, 1'b0);
      for (int i = 4; i >= 1; i--) go(SEL_B, "stop1", 1'b1, PH_STOP1, to_bcd(i), 4'd1, 1'b0);
      go(SEL_B, "rev_load", 1'b1, PH_REV, 8'h12, 4'd1, 1'b0);
      for (int i = 11; i >= 5; i--) go(SEL_B, "rev", 1'b1, PH_REV, to_bcd(i), 4'd1, 1'b0);

      // Pause coinciding with a tick at REV 05: tick is lost.
      pause = 1'b1;
      go(SEL_B, "pause_tick", 1'b1, PH_PAUSED, 8'h05, 4'd1, 1'b0);
      repeat (3) go(SEL_B, "paused_hold", 1'b1, PH_PAUSED, 8'h05, 4'd1, 1'b0);
      pause = 1'b0;
      go(SEL_B, "resume", 1'b0, PH_REV, 8'h05, 4'd1, 1'b0);
      go(SEL_B, "resume_tick", 1'b1, PH_REV, 8'h04, 4'd1, 1'b0);

      // Door interlock on u_a.
      do_reset();
      cycles = 4'd1;
      start = 1'b1;
      go(SEL_A, "start_door", 1'b0, PH_FWD, 8'h03, 4'd1, 1'b0);
      start = 1'b0;
      go(SEL_A, "fwd", 1'b1, PH_FWD, 8'h02, 4'd1, 1'b0);
      door_open = 1'b1;
      go(SEL_A, "door_open", 1'b0, PH_PAUSED, 8'h02, 4'd1, 1'b0);
      go(SEL_A, "door_blink", 1'b1, PH_PAUSED, 8'h02, 4'd1, 1'b1);
      go(SEL_A, "door_blink", 1'b1, PH_PAUSED, 8'h02, 4'd1, 1'b0);
      go(SEL_A, "door_blink", 1'b1, PH_PAUSED, 8'h02, 4'd1, 1'b1);
      door_open = 1'b0;
      go(SEL_A, "door_close", 1'b0, PH_FWD, 8'h02, 4'd1, 1'b1);
      go(SEL_A, "post_door", 1'b1, PH_FWD, 8'h01, 4'd1, 1'b0);
      go(SEL_A, "post_door", 1'b1, PH_STOP1, 8'h01, 4'd1, 1'b1);
      start = 1'b1;
      go(SEL_A, "start_ignored", 1'b0, PH_STOP1, 8'h01, 4'd1, 1'b1);
      start = 1'b0;
      go(SEL_A, "post_door", 1'b1, PH_REV, 8'h03, 4'd1, 1'b0);
      go(SEL_A, "post_door", 1'b1, PH_REV, 8'h02, 4'd1, 1'b1);
      go(SEL_A, "post_door", 1'b1, PH_REV, 8'h01, 4'd1, 1'b0);
      go(SEL_A, "post_door", 1'b1, PH_STOP2, 8'h01, 4'd1, 1'b1);
      go(SEL_A, "door_done", 1'b1, PH_DONE, 8'h00, 4'd0, 1'b0);
      go(SEL_A, "done_blink", 1'b1, PH_DONE, 8'h00, 4'd0, 1'b1);
      start = 1'b1;
      go(SEL_A, "restart", 1'b0, PH_FWD, 8'h03, 4'd1, 1'b0);
      start = 1'b0;
      go(SEL_A, "restart_tick", 1'b1, PH_FWD, 8'h02, 4'd1, 1'b0);

      // Rejected starts (door open, then cycles=0), then a good start.
      do_reset();
      door_open = 1'b1;
      cycles = 4'd1;
      start = 1'b1;
      go(SEL_A, "door_start", 1'b0, PH_IDLE, 8'h00, 4'd0, 1'b0);
      start = 1'b0;
      door_open = 1'b0;
      go(SEL_A, "bad_blink", 1'b1, PH_IDLE, 8'h00, 4'd0, 1'b1);
      cycles = 4'd0;
      start = 1'b1;
      go(SEL_A, "zero_start", 1'b0, PH_IDLE, 8'h00, 4'd0, 1'b1);
      start = 1'b0;
      go(SEL_A, "bad_blink", 1'b1, PH_IDLE, 8'h00, 4'd0, 1'b0);
      go(SEL_A, "bad_blink", 1'b1, PH_IDLE, 8'h00, 4'd0, 1'b1);
      cycles = 4'd1;
      start = 1'b1;
      go(SEL_A, "good_start", 1'b0, PH_FWD, 8'h03, 4'd1, 1'b0);
      start = 1'b0;
      go(SEL_A, "good_tick", 1'b1, PH_FWD, 8'h02, 4'd1, 1'b0);

      // Async reset mid-REV with start held high through it.
      do_reset();
      cycles = 4'd1;
      start = 1'b1;
      go(SEL_A, "start_rst", 1'b0, PH_FWD, 8'h03, 4'd1, 1'b0);
      go(SEL_A, "to_rev", 1'b1, PH_FWD, 8'h02, 4'd1, 1'b0);
      go(SEL_A, "to_rev", 1'b1, PH_FWD, 8'h01, 4'd1, 1'b0);
      go(SEL_A, "to_rev", 1'b1, PH_STOP1, 8'h01, 4'd1, 1'b0);
      go(SEL_A, "to_rev", 1'b1, PH_REV, 8'h03, 4'd1, 1'b0);
      go(SEL_A, "to_rev", 1'b1, PH_REV, 8'h02, 4'd1, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_eq("async_rst.phase", int'(a_phase), int'(PH_IDLE));
      chk_eq("async_rst.remaining", int'(a_rem), 0);
      chk_eq("async_rst.cycles_left", int'(a_cl), 0);
      chk_eq("async_rst.motor_rev", int'(a_rev), 0);
      chk_eq("async_rst.motor_fwd", int'(a_fwd), 0);
      chk_eq("async_rst.done", int'(a_done), 0);
      chk_eq("async_rst.alarm", int'(a_alarm), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) go(SEL_A, "held_start", 1'b0, PH_IDLE, 8'h00, 4'd0, 1'b0);
      start = 1'b0;
      go(SEL_A, "start_low", 1'b0, PH_IDLE, 8'h00, 4'd0, 1'b0);
      start = 1'b1;
      go(SEL_A, "start_again", 1'b0, PH_FWD, 8'h03, 4'd1, 1'b0);
      start = 1'b0;

      @(negedge clk);
      #1;
      chk_eq("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wash_cycle_scheduler.md
Name: wash_cycle_scheduler

Overview:
Sequences one wash program for the washer motor: forward run, stop, reverse run, stop, repeated for a user-selected number of cycles. Owns the BCD phase countdown, the motor direction outputs, and the pause/door interlock. Feeds the panel/display logic with phase, remaining time, cycles left, done and alarm. Driven by the 1 Hz tick from the clock-divider block.

Parameters:
T_RUN, 8'h60, forward/reverse run duration in BCD seconds; 8'h01..8'h99.
T_STOP, 8'h05, stop duration between runs in BCD seconds; 8'h01..8'h99.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
tick  input  1  one-clk-wide 1 Hz enable pulse
start  input  1  level; a rising edge requests a program start
pause  input  1  level; high holds the program
door_open  input  1  level; high = door open
cycles  input  4  number of cycles to run, binary 0..15, sampled on an accepted start
motor_fwd  output  1  forward drive
motor_rev  output  1  reverse drive
phase  output  3  0 IDLE, 1 FWD, 2 STOP1, 3 REV, 4 STOP2, 5 DONE, 6 PAUSED
remaining  output  8  BCD seconds left in the current phase
cycles_left  output  4  cycles not yet completed, including the current one
done  output  1  high in DONE
alarm  output  1  error indication, blinking

Behaviour:
- Reset (rst low, async) forces:
  - state IDLE; all outputs 0.
  - err flag 0, blink 0, start_q 0.
- Start edge = start & ~start_q, with start_q registered every clk.
- Start acceptance:
  - Edge in IDLE or DONE, with cycles != 0 and door_open = 0 -> next clk: FWD, remaining = T_RUN, cycles_left = cycles, err cleared, done 0.
  - Edge in IDLE or DONE with cycles = 0 or door_open = 1 -> state unchanged; err set.
  - Edge in any other state is ignored.
- Countdown:
  - Applies in FWD, STOP1, REV and STOP2 only, on a clk where tick = 1.
  - If remaining == 8'h01, the phase ends: go to the next phase and load its duration in the same clk.
  - Otherwise, BCD decrement: units > 0 -> units - 1; else tens - 1 and units = 9.
  - Each phase therefore lasts exactly its parameter in ticks. Never wraps below 00.
- Transitions at phase end:
  - FWD -> STOP1 (T_STOP).
  - STOP1 -> REV (T_RUN).
  - REV -> STOP2 (T_STOP).
  - STOP2: if cycles_left == 1, go to DONE with remaining 00 and cycles_left 0. Otherwise go to FWD (T_RUN) with cycles_left - 1.
- Pause:
  - Entry: in FWD, STOP1, REV or STOP2, pause = 1 or door_open = 1 -> PAUSED next clk. Save the resume phase; remaining and cycles_left freeze.
  - Door-open entry also sets err.
  - Priority: pause/door beat a tick in the same clk. The tick is lost and remaining is not decremented.
  - Exit: in PAUSED, pause = 0 and door_open = 0 -> return to the saved phase next clk, with the same remaining.
- Motor outputs:
  - Registered: motor_fwd = (state == FWD), motor_rev = (state == REV).
  - Never both high; both are 0 in PAUSED.
- done = (state == DONE). DONE holds until a start edge or reset.
- Alarm:
  - blink toggles on each tick while err = 1 and is forced to 0 when err = 0.
  - alarm = err & blink.
- The cycles input is ignored except on an accepted start.

Decomposition:
- Shared package wash_pkg:
  - Phase encodings (IDLE..PAUSED).
  - BCD constants for default T_RUN/T_STOP.
  - 8-bit BCD type.
- One sub-module, bcd_down_counter8:
  - Inputs: load, load_val, en.
  - Outputs: value, is_one.
  - Same reset and clock as the parent; holds at 00.

Test Plan:
- Normal run: T_RUN = 8'h03, T_STOP = 8'h01, cycles = 2, start edge.
  - Phases follow FWD(3 ticks), STOP1(1), REV(3), STOP2(1), FWD, ... DONE after 16 ticks.
  - cycles_left goes 2 -> 1 -> 0; done = 1; motor_fwd/motor_rev never overlap.
- BCD borrow: T_RUN = 8'h12.
  - remaining in FWD sequences 12, 11, 10, 09, 08 ... 01, then STOP1 loads T_STOP.
  - No value 0F appears.
- Pause with tick: assert pause on the same clk as a tick in REV with remaining = 8'h05.
  - PAUSED, remaining stays 05, motors 0.
  - Release pause -> REV resumes at 05 and next tick gives 04.
- Door interlock: door_open = 1 mid-FWD.
  - PAUSED, err = 1, alarm toggles every tick.
  - Door closed -> FWD resumes; alarm keeps blinking until the next accepted start.
- Bad start: cycles = 0, start edge in IDLE.
  - Stays IDLE, alarm blinks.
  - cycles = 1, new start edge -> FWD, alarm 0.
- Async reset mid-REV, asserted between clk edges.
  - All outputs 0 immediately, phase IDLE.
  - After release, a start held high from before reset is not treated as an edge until it goes low and high again.
